// File: rtl/ltc2311_pkg.sv
// Shared types and sizes for the LTC2311-16 device-side emulator.
package ltc2311_pkg;

    localparam int unsigned LTC2311_DATA_W      = 16;
    localparam int unsigned LTC2311_SYNC_STAGES = 2;
    localparam int unsigned LTC2311_RISE_W      = $clog2(LTC2311_DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2
    } emu_state_t;

endpackage

// File: rtl/ltc2311_pin_sync.sv
// Two-flop synchronizer plus edge-detect register for one asynchronous serial pin.
// Edge flags are combinational off the registered chain, so the FSM acts on the third clk edge.
module ltc2311_pin_sync
    import ltc2311_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [LTC2311_SYNC_STAGES-1:0] r_sync;
    logic                           r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {LTC2311_SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[LTC2311_SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[LTC2311_SYNC_STAGES-1];
        end
    end

    assign o_rise_c = r_sync[LTC2311_SYNC_STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_sync[LTC2311_SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/ltc2311_emulator.sv
// Device-side LTC2311-16 model: watches cnv_n/sck, serializes a 16-bit sample on sdo MSB first.
// Optional internal ramp source compiled in with LTC2311_EMU_PATTERN_EN.
module ltc2311_emulator
    import ltc2311_pkg::*;
#(
    parameter int unsigned                CONV_MIN_CYCLES = 12,
    parameter logic [LTC2311_DATA_W-1:0]  RAMP_STEP       = 16'd1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cnv_n,
    input  logic                      sck,
    output logic                      sdo,
    input  logic [LTC2311_DATA_W-1:0] sample_in,
    input  logic                      pattern_en,
    output logic                      sample_capture,
    output logic                      frame_done,
    output logic [LTC2311_DATA_W-1:0] conv_count,
    input  logic                      clr_status,
    output logic                      timing_err,
    output logic                      trunc_err
);

    localparam int unsigned TIMER_W = (CONV_MIN_CYCLES > 0) ? $clog2(CONV_MIN_CYCLES + 1) : 1;

    logic w_cnv_rise, w_cnv_fall, w_sck_rise, w_sck_fall;

    ltc2311_pin_sync #(.RESET_VAL(1'b0)) u_cnv_sync (
        .clk      (clk),
        .reset    (reset),
        .i_pin    (cnv_n),
        .o_rise_c (w_cnv_rise),
        .o_fall_c (w_cnv_fall)
    );

    ltc2311_pin_sync #(.RESET_VAL(1'b1)) u_sck_sync (
        .clk      (clk),
        .reset    (reset),
        .i_pin    (sck),
        .o_rise_c (w_sck_rise),
        .o_fall_c (w_sck_fall)
    );

    emu_state_t                r_state, w_state_nx;
    logic [LTC2311_DATA_W-1:0] r_shreg, w_shreg_nx;
    logic                      r_sdo, w_sdo_nx;
    logic [TIMER_W-1:0]        r_timer, w_timer_nx;
    logic [LTC2311_RISE_W-1:0] r_rise_cnt, w_rise_cnt_nx, w_rise_inc;
    logic [LTC2311_DATA_W-1:0] r_conv_count, w_conv_count_nx;
    logic                      r_timing_err, w_timing_err_nx;
    logic                      r_trunc_err, w_trunc_err_nx;
    logic                      r_sample_capture, w_sample_capture_nx;
    logic                      r_frame_done, w_frame_done_nx;
    logic                      w_start;
    logic                      w_timer_short;
    logic [LTC2311_DATA_W-1:0] w_sample;

`ifdef LTC2311_EMU_PATTERN_EN
    logic [LTC2311_DATA_W-1:0] r_ramp;

    // Ramp advances only when it was the value handed to the master.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ramp <= '0;
        end else if (w_start && pattern_en) begin
            r_ramp <= r_ramp + RAMP_STEP;
        end
    end

    assign w_sample = pattern_en ? r_ramp : sample_in;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = pattern_en ^ (^RAMP_STEP);
    assign w_sample     = sample_in;
`endif

    assign w_timer_short = (r_timer < TIMER_W'(CONV_MIN_CYCLES));
    assign w_rise_inc    = r_rise_cnt + LTC2311_RISE_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_shreg          <= '0;
            r_sdo            <= 1'b0;
            r_timer          <= '0;
            r_rise_cnt       <= '0;
            r_conv_count     <= '0;
            r_timing_err     <= 1'b0;
            r_trunc_err      <= 1'b0;
            r_sample_capture <= 1'b0;
            r_frame_done     <= 1'b0;
        end else begin
            r_state          <= w_state_nx;
            r_shreg          <= w_shreg_nx;
            r_sdo            <= w_sdo_nx;
            r_timer          <= w_timer_nx;
            r_rise_cnt       <= w_rise_cnt_nx;
            r_conv_count     <= w_conv_count_nx;
            r_timing_err     <= w_timing_err_nx;
            r_trunc_err      <= w_trunc_err_nx;
            r_sample_capture <= w_sample_capture_nx;
            r_frame_done     <= w_frame_done_nx;
        end
    end

    // Next-state logic; cnv events are examined before sck events, flag sets override clr_status.
    always_comb begin
        w_state_nx          = r_state;
        w_shreg_nx          = r_shreg;
        w_sdo_nx            = r_sdo;
        w_timer_nx          = r_timer;
        w_rise_cnt_nx       = r_rise_cnt;
        w_conv_count_nx     = r_conv_count;
        w_timing_err_nx     = r_timing_err & ~clr_status;
        w_trunc_err_nx      = r_trunc_err & ~clr_status;
        w_sample_capture_nx = 1'b0;
        w_frame_done_nx     = 1'b0;
        w_start             = 1'b0;

        case (r_state)
            IDLE: begin
                w_sdo_nx = 1'b0;
                w_start  = w_cnv_rise;
            end
            CONVERT: begin
                w_sdo_nx = 1'b0;
                if (w_timer_short) begin
                    w_timer_nx = r_timer + TIMER_W'(1);
                end
                if (w_cnv_fall) begin
                    if (w_timer_short) begin
                        w_timing_err_nx = 1'b1;
                    end
                    w_sdo_nx      = r_shreg[LTC2311_DATA_W-1];
                    w_shreg_nx    = {r_shreg[LTC2311_DATA_W-2:0], 1'b0};
                    w_rise_cnt_nx = '0;
                    w_state_nx    = SHIFT;
                end
            end
            SHIFT: begin
                if (w_cnv_rise) begin
                    w_trunc_err_nx = 1'b1;
                    w_start        = 1'b1;
                end else if (w_sck_fall) begin
                    // Zero fill makes sdo read 0 once bit 0 has gone out.
                    w_sdo_nx   = r_shreg[LTC2311_DATA_W-1];
                    w_shreg_nx = {r_shreg[LTC2311_DATA_W-2:0], 1'b0};
                end else if (w_sck_rise) begin
                    w_rise_cnt_nx = w_rise_inc;
                    if (w_rise_inc == LTC2311_RISE_W'(LTC2311_DATA_W)) begin
                        w_frame_done_nx = 1'b1;
                        w_sdo_nx        = 1'b0;
                        w_state_nx      = IDLE;
                    end
                end
            end
            default: begin
                w_sdo_nx   = 1'b0;
                w_state_nx = IDLE;
            end
        endcase

        if (w_start) begin
            w_shreg_nx          = w_sample;
            w_sample_capture_nx = 1'b1;
            w_conv_count_nx     = r_conv_count + LTC2311_DATA_W'(1);
            w_timer_nx          = '0;
            w_sdo_nx            = 1'b0;
            w_state_nx          = CONVERT;
        end
    end

    assign sdo            = r_sdo;
    assign sample_capture = r_sample_capture;
    assign frame_done     = r_frame_done;
    assign conv_count     = r_conv_count;
    assign timing_err     = r_timing_err;
    assign trunc_err      = r_trunc_err;

endmodule

// File: tb/tb_ltc2311_emulator.sv
// Bench for ltc2311_emulator: a master task drives cnv_n/sck and reassembles sdo, sampling each bit as it drops sck.
// Expected words, counts and flags come from a frame-level model of the converter's behaviour.
module tb_ltc2311_emulator;

    localparam int unsigned MIN_CYC = 12;
    localparam logic [15:0] TB_RAMP = 16'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cnv_n;
    logic        sck;
    logic        sdo;
    logic [15:0] sample_in;
    logic        pattern_en;
    logic        sample_capture;
    logic        frame_done;
    logic [15:0] conv_count;
    logic        clr_status;
    logic        timing_err;
    logic        trunc_err;

    int checks = 0;
    int errors = 0;
    int n_cap  = 0;
    int n_done = 0;

    logic [15:0] m_count;
    logic        m_terr;
    logic        m_trerr;

    ltc2311_emulator #(
        .CONV_MIN_CYCLES (MIN_CYC),
        .RAMP_STEP       (TB_RAMP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cnv_n          (cnv_n),
        .sck            (sck),
        .sdo            (sdo),
        .sample_in      (sample_in),
        .pattern_en     (pattern_en),
        .sample_capture (sample_capture),
        .frame_done     (frame_done),
        .conv_count     (conv_count),
        .clr_status     (clr_status),
        .timing_err     (timing_err),
        .trunc_err      (trunc_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample_capture) n_cap++;
        if (frame_done)     n_done++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Master: hold cnv_n high, drop it, then clock nbits bits; a bit is read just before each sck fall.
    task automatic run_frame(input logic [15:0] val, input int high, input int nbits,
                             input int half, output logic [15:0] rx);
        rx        = '0;
        sample_in = val;
        cnv_n     = 1'b1;
        tick(high);
        cnv_n = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            rx  = {rx[14:0], sdo};
            sck = 1'b0;
            tick(half);
            sck = 1'b1;
            tick(half);
        end
        tick(6);
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        tick(1);
        m_terr  = 1'b0;
        m_trerr = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        cnv_n      = 1'b0;
        sck        = 1'b1;
        sample_in  = '0;
        pattern_en = 1'b0;
        clr_status = 1'b0;
        m_count    = '0;
        m_terr     = 1'b0;
        m_trerr    = 1'b0;
        tick(3);
        checks++;
        if ({sdo, sample_capture, frame_done, timing_err, trunc_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000",
                     {sdo, sample_capture, frame_done, timing_err, trunc_err});
        end
        checks++;
        if (conv_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_count got %h want 0000", conv_count);
        end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_legal_frame();
        logic [15:0] rx;
        int c0, d0;
        c0 = n_cap;
        d0 = n_done;
        run_frame(16'hA5C3, 20, 16, 4, rx);
        m_count = m_count + 16'd1;
        checks++;
        if (rx !== 16'hA5C3) begin
            errors++;
            $display("FAIL legal_data got %h want a5c3", rx);
        end
        checks++;
        if (n_done - d0 != 1 || n_cap - c0 != 1) begin
            errors++;
            $display("FAIL legal_pulses got done=%0d cap=%0d want 1 1", n_done - d0, n_cap - c0);
        end
        checks++;
        if (conv_count !== m_count) begin
            errors++;
            $display("FAIL legal_count got %h want %h", conv_count, m_count);
        end
        checks++;
        if ({timing_err, trunc_err} !== {m_terr, m_trerr}) begin
            errors++;
            $display("FAIL legal_flags got %b%b want %b%b", timing_err, trunc_err, m_terr, m_trerr);
        end
    endtask

    task automatic test_short_conversion();
        logic [15:0] rx;
        run_frame(16'hA5C3, 4, 16, 4, rx);
        m_count = m_count + 16'd1;
        m_terr  = 1'b1;
        checks++;
        if (rx !== 16'hA5C3) begin
            errors++;
            $display("FAIL short_data got %h want a5c3", rx);
        end
        checks++;
        if (timing_err !== m_terr || trunc_err !== m_trerr) begin
            errors++;
            $display("FAIL short_flags got %b%b want %b%b", timing_err, trunc_err, m_terr, m_trerr);
        end
        pulse_clr();
        checks++;
        if (timing_err !== 1'b0) begin
            errors++;
            $display("FAIL short_clear got %b want 0", timing_err);
        end
    endtask

    task automatic test_truncated();
        logic [15:0] rx;
        int d0;
        d0 = n_done;
        run_frame(16'h1234, 20, 7, 4, rx);
        checks++;
        if (rx !== 16'h1234 >> 9 || n_done != d0) begin
            errors++;
            $display("FAIL trunc_partial got %h done=%0d want %h done=%0d", rx, n_done - d0, 16'h1234 >> 9, 0);
        end
        run_frame(16'h5EED, 20, 16, 4, rx);
        m_count = m_count + 16'd2;
        m_trerr = 1'b1;
        checks++;
        if (rx !== 16'h5EED || n_done - d0 != 1) begin
            errors++;
            $display("FAIL trunc_next got %h done=%0d want 5eed done=1", rx, n_done - d0);
        end
        checks++;
        if (trunc_err !== m_trerr || timing_err !== m_terr || conv_count !== m_count) begin
            errors++;
            $display("FAIL trunc_status got te=%b tr=%b cnt=%h want te=%b tr=%b cnt=%h",
                     timing_err, trunc_err, conv_count, m_terr, m_trerr, m_count);
        end
        pulse_clr();
        checks++;
        if (trunc_err !== 1'b0) begin
            errors++;
            $display("FAIL trunc_clear got %b want 0", trunc_err);
        end
    endtask

    task automatic test_random_frames();
        logic [15:0] rx, val;
        int high, half, d0;
        for (int k = 0; k < 10; k++) begin
            val  = 16'($urandom);
            half = int'($urandom_range(4, 7));
            high = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, MIN_CYC - 3))
                                                : int'($urandom_range(MIN_CYC + 2, 30));
`ifdef LTC2311_EMU_PATTERN_EN
            pattern_en = 1'b0;
`else
            pattern_en = 1'($urandom);
`endif
            d0 = n_done;
            run_frame(val, high, 16, half, rx);
            m_count = m_count + 16'd1;
            if (high < int'(MIN_CYC)) m_terr = 1'b1;
            checks++;
            if (rx !== val || n_done - d0 != 1) begin
                errors++;
                $display("FAIL rand_data[%0d] got %h done=%0d want %h done=1", k, rx, n_done - d0, val);
            end
            checks++;
            if (conv_count !== m_count || timing_err !== m_terr || trunc_err !== m_trerr) begin
                errors++;
                $display("FAIL rand_status[%0d] got cnt=%h te=%b tr=%b want cnt=%h te=%b tr=%b",
                         k, conv_count, timing_err, trunc_err, m_count, m_terr, m_trerr);
            end
        end
        pattern_en = 1'b0;
        pulse_clr();
    endtask

    task automatic test_pattern();
        logic [15:0] rx, exp_v;
        logic [15:0] m_ramp;
        m_ramp     = 16'h0000;
        pattern_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
`ifdef LTC2311_EMU_PATTERN_EN
            exp_v  = m_ramp;
            m_ramp = m_ramp + TB_RAMP;
`else
            exp_v = 16'hC0DE ^ 16'(k);
`endif
            run_frame(16'hC0DE ^ 16'(k), 20, 16, 4, rx);
            m_count = m_count + 16'd1;
            checks++;
            if (rx !== exp_v) begin
                errors++;
                $display("FAIL pattern[%0d] got %h want %h", k, rx, exp_v);
            end
        end
        pattern_en = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic [15:0] rx;
        logic        seen;
        int          d0;
        sample_in = 16'hF0F0;
        cnv_n     = 1'b1;
        tick(20);
        cnv_n = 1'b0;
        tick(8);
        for (int i = 0; i < 5; i++) begin
            sck = 1'b0;
            tick(4);
            sck = 1'b1;
            tick(4);
        end
        reset = 1'b1;
        #1;
        m_count = '0;
        m_terr  = 1'b0;
        m_trerr = 1'b0;
        checks++;
        if (sdo !== 1'b0 || conv_count !== 16'h0) begin
            errors++;
            $display("FAIL midreset_now got sdo=%b cnt=%h want sdo=0 cnt=0000", sdo, conv_count);
        end
        tick(2);
        reset = 1'b0;
        tick(2);
        seen = 1'b0;
        d0   = n_done;
        for (int i = 0; i < 20; i++) begin
            sck = 1'b0;
            tick(4);
            seen = seen | sdo;
            sck = 1'b1;
            tick(4);
            seen = seen | sdo;
        end
        checks++;
        if (seen !== 1'b0 || n_done != d0) begin
            errors++;
            $display("FAIL midreset_idle got sdo_seen=%b done=%0d want 0 0", seen, n_done - d0);
        end
        run_frame(16'h8001, 20, 16, 4, rx);
        m_count = m_count + 16'd1;
        checks++;
        if (rx !== 16'h8001 || conv_count !== m_count) begin
            errors++;
            $display("FAIL midreset_next got %h cnt=%h want 8001 cnt=%h", rx, conv_count, m_count);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] rx;
        force dut.r_conv_count = 16'hFFFF;
        tick(1);
        release dut.r_conv_count;
        m_count = 16'hFFFF;
        run_frame(16'h7E57, 20, 16, 4, rx);
        m_count = m_count + 16'd1;
        checks++;
        if (conv_count !== m_count || rx !== 16'h7E57) begin
            errors++;
            $display("FAIL wrap got cnt=%h data=%h want cnt=%h data=7e57", conv_count, rx, m_count);
        end
        checks++;
        if (timing_err !== 1'b0 || trunc_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_flags got %b%b want 00", timing_err, trunc_err);
        end
    endtask

    initial begin
        test_reset();
        test_legal_frame();
        test_short_conversion();
        test_truncated();
        test_random_frames();
        test_pattern();
        test_reset_mid_shift();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
